bcd2bin: RTL and testbench

Multi-cycle BCD-to-binary converter using reverse double-dabble (shift right, subtract 3). It is the inverse companion of the team's binary-to-BCD converter. It takes a packed BCD value on a start pulse and returns the binary equivalent with a one-cycle data-valid strobe. It sits behind keypad/display-entry paths where operators enter decimal digits that downstream arithmetic consumes as binary.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd2bin.sv | 161 ++++++++++++++++
 tb/tb_bcd2bin.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared state encodings and helpers for the BCD/binary converter pair.
package bcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'b000,
      ST_SHIFT       = 3'b001,
      ST_CHECK_SHIFT = 3'b010,
      ST_SUB         = 3'b011,
      ST_CHECK_DIGIT = 3'b100,
      ST_DONE        = 3'b101
   } state_t;

   // Reverse double-dabble digit correction: a digit of 8 or more after a
   // right shift held a carried-in 5 that must come back out as 3.
   function automatic logic [3:0] digit_fix(input logic [3:0] d);
      return (d >= 4'd8) ? (d - 4'd3) : d;
   endfunction

endpackage

// File: rtl/bcd2bin.sv
// Multi-cycle packed-BCD to binary converter (reverse double-dabble).
//
// state          | meaning
// ---------------+----------------------------------------------------
// ST_IDLE        | waiting for i_Start; validates digits, loads work reg
// ST_SHIFT       | shift {bcd, bin} right by one
// ST_CHECK_SHIFT | last shift done -> DONE, else start a digit pass
// ST_SUB         | correct the digit selected by dig_idx
// ST_CHECK_DIGIT | advance digit index or return to SHIFT
// ST_DONE        | publish result and error, strobe o_DV
module bcd2bin
   import bcd_pkg::*;
#(
   parameter int DECIMAL_DIGITS = 2,
   parameter int OUTPUT_WIDTH   = 7
) (
   input  logic                        i_Clock,
   input  logic                        i_Reset,
   input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
   input  logic                        i_Start,
   output logic [OUTPUT_WIDTH-1:0]     o_Binary,
   output logic                        o_DV,
   output logic                        o_Error,
   output logic                        o_Busy
);

   localparam int BCD_W = DECIMAL_DIGITS * 4;
   localparam int CNT_W = $clog2(OUTPUT_WIDTH) + 1;
   localparam int IDX_W = $clog2(DECIMAL_DIGITS) + 1;

   localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(OUTPUT_WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DECIMAL_DIGITS - 1);

   state_t                  state_q, state_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [OUTPUT_WIDTH-1:0] bin_q, bin_d;
   logic                    err_q, err_d;
   logic [CNT_W-1:0]        shift_cnt_q, shift_cnt_d;
   logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
   logic [OUTPUT_WIDTH-1:0] binary_q, binary_d;
   logic                    dv_q, dv_d;
   logic                    error_q, error_d;
   logic                    bad_digit;

   // Flag any input digit above 9.
   always_comb begin
      bad_digit = 1'b0;
      for (int k = 0; k < DECIMAL_DIGITS; k++) begin
         if (i_BCD[k*4 +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end

   // Next-state and datapath; shift_cnt is a down-counter with a zero
   // terminal count, loaded with the number of corrective passes.
   always_comb begin
      state_d     = state_q;
      bcd_d       = bcd_q;
      bin_d       = bin_q;
      err_d       = err_q;
      shift_cnt_d = shift_cnt_q;
      dig_idx_d   = dig_idx_q;
      binary_d    = binary_q;
      dv_d        = 1'b0;
      error_d     = error_q;

      case (state_q)
         ST_IDLE: begin
            if (i_Start) begin
               if (bad_digit) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  bcd_d       = i_BCD;
                  bin_d       = '0;
                  err_d       = 1'b0;
                  shift_cnt_d = SHIFT_LOAD;
                  dig_idx_d   = '0;
                  state_d     = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
            state_d        = ST_CHECK_SHIFT;
         end
         ST_CHECK_SHIFT: begin
            if (shift_cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               shift_cnt_d = shift_cnt_q - CNT_W'(1);
               state_d     = ST_SUB;
            end
         end
         ST_SUB: begin
            for (int k = 0; k < DECIMAL_DIGITS; k++) begin
               if (dig_idx_q == IDX_W'(k)) begin
                  bcd_d[k*4 +: 4] = digit_fix(bcd_q[k*4 +: 4]);
               end
            end
            state_d = ST_CHECK_DIGIT;
         end
         ST_CHECK_DIGIT: begin
            if (dig_idx_q == IDX_LAST) begin
               dig_idx_d = '0;
               state_d   = ST_SHIFT;
            end else begin
               dig_idx_d = dig_idx_q + IDX_W'(1);
               state_d   = ST_SUB;
            end
         end
         ST_DONE: begin
            dv_d = 1'b1;
            if (err_q) begin
               binary_d = '0;
               error_d  = 1'b1;
            end else begin
               // Residual BCD means the value did not fit the output width.
               binary_d = bin_q;
               error_d  = |bcd_q;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q     <= ST_IDLE;
         bcd_q       <= '0;
         bin_q       <= '0;
         err_q       <= 1'b0;
         shift_cnt_q <= '0;
         dig_idx_q   <= '0;
         binary_q    <= '0;
         dv_q        <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcd_q       <= bcd_d;
         bin_q       <= bin_d;
         err_q       <= err_d;
         shift_cnt_q <= shift_cnt_d;
         dig_idx_q   <= dig_idx_d;
         binary_q    <= binary_d;
         dv_q        <= dv_d;
         error_q     <= error_d;
      end
   end

   assign o_Binary = binary_q;
   assign o_DV     = dv_q;
   assign o_Error  = error_q;
   assign o_Busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: a 7-bit (full range) and a 6-bit
// (overflowing) instance, each with its own start/data inputs.
module tb_bcd2bin;

   typedef struct {
      logic [6:0] bin;
      logic       err;
      int         start_cyc;
      int         dv_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] bcd7 = 8'h00, bcd6 = 8'h00;
   logic       start7 = 1'b0, start6 = 1'b0;
   logic [6:0] bin7;
   logic [5:0] bin6;
   logic       dv7, dv6, err7, err6, busy7, busy6;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [6:0] last_b [2];
   bit         hold_ok [2];

   bcd2bin #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(7)) dut7 (
      .i_Clock(clk), .i_Reset(rst), .i_BCD(bcd7), .i_Start(start7),
      .o_Binary(bin7), .o_DV(dv7), .o_Error(err7), .o_Busy(busy7)
   );

   bcd2bin #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(6)) dut6 (
      .i_Clock(clk), .i_Reset(rst), .i_BCD(bcd6), .i_Start(start6),
      .o_Binary(bin6), .o_DV(dv6), .o_Error(err6), .o_Busy(busy6)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: decimal value from the digits, reduced to the output width.
   function automatic exp_t model(input int u, input logic [7:0] bcd);
      exp_t e;
      int   d0, d1, w, v, lat;
      d0 = int'(bcd[3:0]);
      d1 = int'(bcd[7:4]);
      w  = (u == 0) ? 7 : 6;
      if (d0 > 9 || d1 > 9) begin
         e.bin = 7'd0;
         e.err = 1'b1;
         lat   = 1;
      end else begin
         v     = d1 * 10 + d0;
         e.err = (v >= (1 << w));
         e.bin = 7'(v % (1 << w));
         lat   = 2 * w + 2 * 2 * (w - 1) + 1;
      end
      e.start_cyc = 0;
      e.dv_cyc    = lat;
      return e;
   endfunction

   // Call just after a falling edge; returns after the start edge.
   task automatic convert(input int u, input logic [7:0] bcd);
      exp_t e;
      e = model(u, bcd);
      e.start_cyc = cyc + 1;
      e.dv_cyc    = cyc + 1 + e.dv_cyc;
      if (u == 0) begin
         q0.push_back(e);
         bcd7   = bcd;
         start7 = 1'b1;
      end else begin
         q1.push_back(e);
         bcd6   = bcd;
         start6 = 1'b1;
      end
      @(negedge clk);
      if (u == 0) start7 = 1'b0;
      else        start6 = 1'b0;
   endtask

   task automatic wait_dv(input int u);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         seen = (u == 0) ? dv7 : dv6;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_dv unit %0d: got no o_DV, expected one within 100 cycles", u);
      end
   endtask

   task automatic run_both(input logic [7:0] bcd);
      fork
         begin convert(0, bcd); wait_dv(0); end
         begin convert(1, bcd); wait_dv(1); end
      join
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_bin7"},  int'(bin7),  0);
      chk({tag, "_dv7"},   int'(dv7),   0);
      chk({tag, "_err7"},  int'(err7),  0);
      chk({tag, "_busy7"}, int'(busy7), 0);
      chk({tag, "_bin6"},  int'(bin6),  0);
      chk({tag, "_dv6"},   int'(dv6),   0);
      chk({tag, "_err6"},  int'(err6),  0);
      chk({tag, "_busy6"}, int'(busy6), 0);
   endtask

   task automatic mon_unit(input int u, input logic dv, input logic [6:0] b,
                           input logic e, input logic busy);
      exp_t f;
      int   n;
      n = (u == 0) ? q0.size() : q1.size();
      if (n > 0) f = (u == 0) ? q0[0] : q1[0];
      if (dv) begin
         chk($sformatf("dv_cycle_u%0d", u), cyc, (n > 0) ? f.dv_cyc : -1);
         if (n > 0) begin
            chk($sformatf("binary_u%0d", u), int'(b), int'(f.bin));
            chk($sformatf("error_u%0d", u), int'(e), int'(f.err));
            chk($sformatf("busy_at_dv_u%0d", u), int'(busy), 0);
            if (u == 0) f = q0.pop_front();
            else        f = q1.pop_front();
         end
      end else begin
         if (n > 0 && cyc >= f.dv_cyc) begin
            chk($sformatf("dv_missing_u%0d", u), 0, 1);
            if (u == 0) f = q0.pop_front();
            else        f = q1.pop_front();
         end else if (n > 0 && cyc >= f.start_cyc) begin
            chk($sformatf("busy_u%0d", u), int'(busy), 1);
         end
         if (hold_ok[u] && !rst) begin
            chk($sformatf("binary_hold_u%0d", u), int'(b), int'(last_b[u]));
         end
      end
      last_b[u]  = b;
      hold_ok[u] = !rst;
   endtask

   always @(negedge clk) begin
      mon_unit(0, dv7, bin7, err7, busy7);
      mon_unit(1, dv6, {1'b0, bin6}, err6, busy6);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      hold_ok[0] = 1'b0;
      hold_ok[1] = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed values, including overflow on the 6-bit unit.
      run_both(8'h99);
      run_both(8'h00);
      run_both(8'h45);
      run_both(8'h63);
      run_both(8'h9A);
      run_both(8'hA0);
      @(negedge clk);

      // Start during a conversion, with i_BCD changed, must be ignored.
      convert(0, 8'h27);
      repeat (5) @(negedge clk);
      bcd7   = 8'h81;
      start7 = 1'b1;
      @(negedge clk);
      start7 = 1'b0;
      wait_dv(0);
      @(negedge clk);

      // Randomized traffic with random gaps, occasionally back-to-back.
      fork
         for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) v = 8'($urandom_range(0, 255));
            else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            convert(0, v);
            wait_dv(0);
         end
         for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) v = 8'($urandom_range(0, 255));
            else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            convert(1, v);
            wait_dv(1);
         end
      join

      // Exhaustive valid range, each start issued in the o_DV cycle.
      fork
         for (int v = 0; v < 100; v++) begin
            convert(0, {4'(v / 10), 4'(v % 10)});
            wait_dv(0);
         end
         for (int v = 0; v < 100; v++) begin
            convert(1, {4'(v / 10), 4'(v % 10)});
            wait_dv(1);
         end
      join
      @(negedge clk);

      // Reset ten cycles into a conversion: outputs clear, no strobe.
      fork
         convert(0, 8'h45);
         convert(1, 8'h45);
      join
      repeat (9) @(negedge clk);
      #2;
      q0.delete();
      q1.delete();
      rst = 1'b1;
      #1;
      check_idle_outputs("abort");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      run_both(8'h12);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", q0.size() + q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
